// File: rtl/controle_temporizador_if.sv
// Control bus between user logic / digit-counter chain and the timer FSM.
// Carries start/pause/clear and tc_in in, load/en/busy/done out.
interface controle_temporizador_if #(
  parameter int NUM_DIGITS = 4
);
  logic                  start;
  logic                  pause;
  logic                  clear;
  logic [NUM_DIGITS-1:0] tc_in;
  logic                  load;
  logic [NUM_DIGITS-1:0] en;
  logic                  busy;
  logic                  done;

  modport master (
    output start, pause, clear, tc_in,
    input  load, en, busy, done
  );

  modport slave (
    input  start, pause, clear, tc_in,
    output load, en, busy, done
  );
endinterface

// File: rtl/controle_temporizador.sv
// Countdown-timer FSM: loads a cascaded digit down-counter chain, then steps
// it once per prescaled tick, gating each digit by the borrows below it and
// stopping at all-zero. Ports: clk, reset (async, active-high), bus (slave):
// start/pause/clear/tc_in in, load/en/busy/done out.
// Optional: define ALARM_TIMEOUT_EN to auto-return DONE -> IDLE after
// ALARM_TICKS ticks.
module controle_temporizador #(
  parameter int NUM_DIGITS  = 4,
  parameter int TICK_DIV    = 4,
  parameter int ALARM_TICKS = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  controle_temporizador_if.slave bus
);

  localparam int PCW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PCW-1:0] PC_MAX =
    PCW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t                state;
  state_t                nxt;
  logic [PCW-1:0]        pc;
  logic                  load_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  tick;
  logic                  pc_top;
  logic                  all_tc;
  logic                  alarm_exp;
  logic [NUM_DIGITS-1:0] borrow;
  logic [NUM_DIGITS-1:0] en_w;

  assign pc_top = (pc == PC_MAX);
  assign tick   = (state == RUN) && pc_top;
  assign all_tc = &bus.tc_in;

`ifdef ALARM_TIMEOUT_EN
  localparam int AW =
    (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;

  logic [AW-1:0] acnt;

  assign alarm_exp = (state == DONE) && pc_top &&
                     (acnt == AW'(ALARM_TICKS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acnt <= '0;
    end else if (state != DONE) begin
      acnt <= '0;
    end else if (pc_top) begin
      acnt <= acnt + 1'b1;
    end
  end
`else
  logic unused_alarm;

  assign alarm_exp    = 1'b0;
  assign unused_alarm = (ALARM_TICKS != 0);
`endif

  // Digit i may step only when every lower digit sits at zero.
  always_comb begin
    logic [NUM_DIGITS-1:0] m;
    borrow = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      m = (NUM_DIGITS'(1) << i) - NUM_DIGITS'(1);
      borrow[i] = ((bus.tc_in & m) == m);
    end
  end

  // A tick is dropped if it meets pause/clear or the chain is at zero.
  always_comb begin
    en_w = '0;
    if (tick && !clear_i() && !bus.pause && !all_tc)
      en_w = borrow;
  end

  function automatic logic clear_i();
    return bus.clear;
  endfunction

  always_comb begin
    nxt = state;
    if (bus.clear) begin
      nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!bus.pause && bus.start)
            nxt = LOAD;
        end
        LOAD: begin
          nxt = RUN;
        end
        RUN: begin
          if (bus.pause)
            nxt = PAUSE;
          else if (tick && all_tc)
            nxt = DONE;
        end
        PAUSE: begin
          if (!bus.pause && bus.start)
            nxt = RUN;
        end
        DONE: begin
          if (!bus.pause && bus.start)
            nxt = LOAD;
          else if (alarm_exp)
            nxt = IDLE;
        end
        default: begin
          nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      pc     <= '0;
      load_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= nxt;
      load_q <= (nxt == LOAD);
      busy_q <= (nxt == LOAD) ||
                (nxt == RUN)  ||
                (nxt == PAUSE);
      done_q <= (nxt == DONE);
      if (bus.clear) begin
        pc <= '0;
      end else begin
        unique case (state)
          RUN: begin
            // Pause freezes pc so resume keeps phase.
            if (!bus.pause)
              pc <= pc_top ? '0 : pc + 1'b1;
          end
          PAUSE: begin
            pc <= pc;
          end
          DONE: begin
`ifdef ALARM_TIMEOUT_EN
            pc <= pc_top ? '0 : pc + 1'b1;
`else
            pc <= '0;
`endif
          end
          default: begin
            pc <= '0;
          end
        endcase
      end
    end
  end

  assign bus.load = load_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.en   = en_w;

endmodule

// File: tb/tb_controle_temporizador.sv
// Directed bench: FSM driving a mod10 (LS) + mod6 (MS) down-counter chain.
// Loads 8'h12, checks countdown, borrow, pause, priority, reset, zero load.
module tb_controle_temporizador;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  controle_temporizador_if #(.NUM_DIGITS(2)) bus ();

  controle_temporizador #(
    .NUM_DIGITS (2),
    .TICK_DIV   (4),
    .ALARM_TICKS(3)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [3:0] d0 = 4'd0;
  logic [3:0] d1 = 4'd0;
  logic [7:0] ldval = 8'h12;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (bus.load) begin
      d1 <= ldval[7:4];
      d0 <= ldval[3:0];
    end else begin
      if (bus.en[0])
        d0 <= (d0 == 4'd0) ? 4'd9 : d0 - 4'd1;
      if (bus.en[1])
        d1 <= (d1 == 4'd0) ? 4'd5 : d1 - 4'd1;
    end
  end

  assign bus.tc_in = {d1 == 4'd0, d0 == 4'd0};
  assign cnt = {d1, d0};

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    nvec++;
    assert (obs === want) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int rem;
    logic [7:0] e;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.clear = 1'b0;

    #12;
    chk("rst_load", bus.load, 0);
    chk("rst_en", bus.en, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    reset = 1'b0;
    repeat (3) begin
      step();
      chk("idle_busy", bus.busy, 0);
    end

    bus.start = 1'b1;
    step();
    chk("ld_load", bus.load, 1);
    chk("ld_busy", bus.busy, 1);
    chk("ld_en", bus.en, 0);
    bus.start = 1'b0;
    step();
    chk("run_load", bus.load, 0);
    chk("run_cnt", cnt, 8'h12);

    for (int k = 1; k <= 13; k++) begin
      for (int p = 0; p < 3; p++) begin
        chk("en_gap", bus.en, 0);
        step();
      end
      rem = 13 - k;
      if (k == 13)
        chk("en_zero", bus.en, 0);
      else if (rem % 10 == 0)
        chk("borrow_en", bus.en, 2'b11);
      else
        chk("tick_en", bus.en, 2'b01);
      step();
      if (k <= 12) begin
        e = 8'(((12 - k) / 10) * 16 + (12 - k) % 10);
        chk("cnt", cnt, e);
        chk("run_done", bus.done, 0);
      end else begin
        chk("done_set", bus.done, 1);
        chk("done_busy", bus.busy, 0);
        chk("done_cnt", cnt, 8'h00);
      end
    end

`ifdef ALARM_TIMEOUT_EN
    repeat (11) begin
      step();
      chk("alarm_hold", bus.done, 1);
      chk("alarm_en", bus.en, 0);
    end
    step();
    chk("alarm_drop", bus.done, 0);
    chk("alarm_busy", bus.busy, 0);
`else
    repeat (100) begin
      step();
      chk("done_hold", bus.done, 1);
      chk("done_en", bus.en, 0);
    end
`endif
    chk("hold_cnt", cnt, 8'h00);

    bus.start = 1'b1;
    step();
    chk("rs_load", bus.load, 1);
    bus.start = 1'b0;
    step();
    chk("rs_cnt", cnt, 8'h12);
    chk("rs_done", bus.done, 0);
    chk("rs_busy", bus.busy, 1);

    repeat (20) step();
    chk("p_cnt", cnt, 8'h07);
    repeat (2) step();
    chk("p_en", bus.en, 0);
    bus.pause = 1'b1;
    bus.start = 1'b1;
    step();
    repeat (20) begin
      chk("frz_en", bus.en, 0);
      chk("frz_cnt", cnt, 8'h07);
      chk("frz_busy", bus.busy, 1);
      step();
    end
    bus.pause = 1'b0;
    step();
    chk("resume_pc2", bus.en, 0);
    bus.start = 1'b0;
    step();
    chk("resume_en", bus.en, 2'b01);
    step();
    chk("resume_cnt", cnt, 8'h06);

    repeat (3) step();
    chk("pre_lost", bus.en, 2'b01);
    bus.pause = 1'b1;
    #1;
    chk("tick_lost", bus.en, 0);
    step();
    chk("lost_cnt", cnt, 8'h06);
    bus.pause = 1'b0;
    bus.start = 1'b1;
    step();
    chk("held_tick", bus.en, 2'b01);
    bus.start = 1'b0;
    step();
    chk("held_cnt", cnt, 8'h05);

    bus.clear = 1'b1;
    bus.pause = 1'b1;
    bus.start = 1'b1;
    step();
    chk("clr_busy", bus.busy, 0);
    chk("clr_done", bus.done, 0);
    chk("clr_load", bus.load, 0);
    bus.clear = 1'b0;
    bus.pause = 1'b0;
    bus.start = 1'b0;
    repeat (5) begin
      step();
      chk("clr_idle", bus.busy, 0);
      chk("clr_cnt", cnt, 8'h05);
    end

    bus.start = 1'b1;
    step();
    chk("rl_load", bus.load, 1);
    bus.start = 1'b0;
    reset = 1'b1;
    #1;
    chk("arst_load", bus.load, 0);
    chk("arst_busy", bus.busy, 0);
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("arst_idle", bus.busy, 0);

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    chk("r2_cnt", cnt, 8'h12);
    repeat (3) step();
    chk("r2_en", bus.en, 2'b01);
    reset = 1'b1;
    #1;
    chk("mrst_en", bus.en, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_load", bus.load, 0);
    chk("mrst_done", bus.done, 0);
    step();
    reset = 1'b0;
    repeat (3) begin
      step();
      chk("mrst_idle", bus.busy, 0);
      chk("mrst_cnt", cnt, 8'h12);
    end

    ldval = 8'h00;
    bus.start = 1'b1;
    step();
    chk("z_load", bus.load, 1);
    bus.start = 1'b0;
    step();
    chk("z_cnt", cnt, 8'h00);
    chk("z_busy", bus.busy, 1);
    repeat (3) step();
    chk("z_en", bus.en, 0);
    step();
    chk("z_done", bus.done, 1);
    chk("z_busy2", bus.busy, 0);
    chk("z_cnt2", cnt, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
